// File: rtl/sram_port_arbiter.sv
// Shares one SRAM-like bridge port among NREQ requesters: round-robin grant locked until addr_ok,
// with an in-order ID FIFO that steers each data_ok/rdata back to the requester that issued it.
module sram_port_arbiter #(
  parameter int NREQ        = 3,
  parameter int ID_W        = 2,
  parameter int OUTSTANDING = 4,
  parameter int CNT_W       = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NREQ-1:0]      m_req,
  input  logic [NREQ-1:0]      m_wr,
  input  logic [2*NREQ-1:0]    m_size,
  input  logic [32*NREQ-1:0]   m_addr,
  input  logic [4*NREQ-1:0]    m_wstrb,
  input  logic [32*NREQ-1:0]   m_wdata,
  output logic [NREQ-1:0]      m_addr_ok,
  output logic [NREQ-1:0]      m_data_ok,
  output logic [31:0]          m_rdata,
  output logic                 s_req,
  output logic                 s_wr,
  output logic [1:0]           s_size,
  output logic [31:0]          s_addr,
  output logic [3:0]           s_wstrb,
  output logic [31:0]          s_wdata,
  input  logic                 s_addr_ok,
  input  logic                 s_data_ok,
  input  logic [31:0]          s_rdata,
  output logic                 err
);

  localparam int PTR_W = (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;

  typedef enum logic {IDLE, LOCKED} state_t;

  state_t             state_q;
  logic [ID_W-1:0]    lock_id_q;
  logic [ID_W-1:0]    rr_ptr_q;
  logic [ID_W-1:0]    fifo_q [OUTSTANDING];
  logic [PTR_W-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CNT_W-1:0]   count_q;
  logic               err_q;
  logic               blank_q;

  logic               blank;
  logic               cand_vld;
  logic [ID_W-1:0]    cand_id;
  logic [ID_W-1:0]    grant_id;
  logic               req_raw;
  logic               full;
  logic               accept;
  logic               pop;
  logic               orphan;
  int                 idx;

  // Outputs are held at zero while reset is asserted and for the cycle right after it.
  assign blank = reset | blank_q;
  assign full  = (count_q == CNT_W'(OUTSTANDING));

  // Lowest k wins, so iterate downward and let later (smaller k) hits overwrite.
  always_comb begin
    cand_vld = 1'b0;
    cand_id  = '0;
    idx      = 0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      idx = int'(rr_ptr_q) + k;
      if (idx >= NREQ) idx = idx - NREQ;
      if (m_req[idx]) begin
        cand_vld = 1'b1;
        cand_id  = ID_W'(idx);
      end
    end
  end

  always_comb begin
    if (state_q == LOCKED) begin
      grant_id = lock_id_q;
      req_raw  = m_req[lock_id_q];
    end else begin
      grant_id = cand_id;
      req_raw  = cand_vld && !full;
    end
  end

  assign s_req   = req_raw && !blank;
  assign accept  = s_req && s_addr_ok;
  assign pop     = s_data_ok && (count_q != '0) && !blank;
  assign orphan  = s_data_ok && (count_q == '0) && !blank;

  assign s_wr    = s_req ? m_wr[grant_id]             : 1'b0;
  assign s_size  = s_req ? m_size[grant_id*2 +: 2]    : 2'd0;
  assign s_addr  = s_req ? m_addr[grant_id*32 +: 32]  : 32'd0;
  assign s_wstrb = s_req ? m_wstrb[grant_id*4 +: 4]   : 4'd0;
  assign s_wdata = s_req ? m_wdata[grant_id*32 +: 32] : 32'd0;

  assign m_addr_ok = accept ? (NREQ'(1) << grant_id) : '0;
  assign m_data_ok = pop ? (NREQ'(1) << fifo_q[rd_ptr_q]) : '0;
  assign m_rdata   = blank ? 32'd0 : s_rdata;
  assign err       = err_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= IDLE;
      lock_id_q <= '0;
      rr_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      err_q     <= 1'b0;
      blank_q   <= 1'b1;
    end else begin
      blank_q <= 1'b0;
      case (state_q)
        IDLE: if (s_req && !s_addr_ok) begin
          state_q   <= LOCKED;
          lock_id_q <= grant_id;
        end
        LOCKED: if (!s_req || s_addr_ok) state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
      if (accept) begin
        fifo_q[wr_ptr_q] <= grant_id;
        wr_ptr_q <= (wr_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : wr_ptr_q + 1'b1;
        rr_ptr_q <= (grant_id == ID_W'(NREQ - 1)) ? '0 : grant_id + 1'b1;
      end
      if (pop)
        rd_ptr_q <= (rd_ptr_q == PTR_W'(OUTSTANDING - 1)) ? '0 : rd_ptr_q + 1'b1;
      if (accept && !pop)      count_q <= count_q + 1'b1;
      else if (!accept && pop) count_q <= count_q - 1'b1;
      if (orphan) err_q <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Directed bench for sram_port_arbiter: reset, single read, round robin, full, lock, ordering, orphan.
module tb_sram_port_arbiter;

  logic         clk = 1'b0;
  logic         reset;
  logic [2:0]   m_req, m_wr;
  logic [5:0]   m_size;
  logic [95:0]  m_addr, m_wdata;
  logic [11:0]  m_wstrb;
  logic [2:0]   m_addr_ok, m_data_ok;
  logic [31:0]  m_rdata;
  logic         s_req, s_wr;
  logic [1:0]   s_size;
  logic [31:0]  s_addr, s_wdata;
  logic [3:0]   s_wstrb;
  logic         s_addr_ok, s_data_ok;
  logic [31:0]  s_rdata;
  logic         err;

  int n_chk  = 0;
  int n_fail = 0;

  localparam logic [31:0] A0 = 32'hA000_0000;
  localparam logic [31:0] A1 = 32'hA000_0100;
  localparam logic [31:0] A2 = 32'hA000_0200;

  always #5 clk = ~clk;

  sram_port_arbiter dut (
    .clk(clk), .reset(reset),
    .m_req(m_req), .m_wr(m_wr), .m_size(m_size), .m_addr(m_addr),
    .m_wstrb(m_wstrb), .m_wdata(m_wdata),
    .m_addr_ok(m_addr_ok), .m_data_ok(m_data_ok), .m_rdata(m_rdata),
    .s_req(s_req), .s_wr(s_wr), .s_size(s_size), .s_addr(s_addr),
    .s_wstrb(s_wstrb), .s_wdata(s_wdata),
    .s_addr_ok(s_addr_ok), .s_data_ok(s_data_ok), .s_rdata(s_rdata),
    .err(err)
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset;
    m_req = 3'b000; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    reset = 1'b1;
    tick;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b1; m_req = 3'b111; s_addr_ok = 1'b1; s_data_ok = 1'b1; s_rdata = 32'h1234_5678;
    @(negedge clk);
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL rst_s_req: got %b want 0", s_req); end
    n_chk++; if (m_addr_ok !== 3'b000) begin n_fail++; $display("FAIL rst_addr_ok: got %b want 000", m_addr_ok); end
    n_chk++; if (m_data_ok !== 3'b000) begin n_fail++; $display("FAIL rst_data_ok: got %b want 000", m_data_ok); end
    n_chk++; if (m_rdata !== 32'd0) begin n_fail++; $display("FAIL rst_rdata: got %h want 0", m_rdata); end
    n_chk++; if (s_addr !== 32'd0) begin n_fail++; $display("FAIL rst_s_addr: got %h want 0", s_addr); end
    tick;
    reset = 1'b0; m_req = 3'b000; s_addr_ok = 1'b0; s_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL post_rst_s_req: got %b want 0", s_req); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL post_rst_err: got %b want 0", err); end
    n_chk++; if (m_rdata !== 32'd0) begin n_fail++; $display("FAIL post_rst_rdata: got %h want 0", m_rdata); end
    tick;
  endtask

  task automatic test_single_read;
    m_req = 3'b010; s_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (m_addr_ok !== 3'b010) begin n_fail++; $display("FAIL single_addr_ok: got %b want 010", m_addr_ok); end
    n_chk++; if (s_addr !== A1) begin n_fail++; $display("FAIL single_s_addr: got %h want %h", s_addr, A1); end
    n_chk++; if ({s_wr, s_size, s_wstrb} !== {1'b0, 2'd1, 4'h3}) begin
      n_fail++; $display("FAIL single_fields: got %b want 0_01_0011", {s_wr, s_size, s_wstrb}); end
    tick;
    m_req = 3'b000; s_addr_ok = 1'b0; s_data_ok = 1'b1; s_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    n_chk++; if (m_data_ok !== 3'b010) begin n_fail++; $display("FAIL single_data_ok: got %b want 010", m_data_ok); end
    n_chk++; if (m_rdata !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL single_rdata: got %h want deadbeef", m_rdata); end
    tick;
    s_data_ok = 1'b0;
  endtask

  // Leaves four transactions outstanding (0,1,2,0) and rr pointer at 1.
  task automatic test_round_robin;
    logic [2:0]  exp_g [4];
    logic [31:0] exp_a [4];
    exp_g = '{3'b001, 3'b010, 3'b100, 3'b001};
    exp_a = '{A0, A1, A2, A0};
    do_reset;
    m_req = 3'b111; s_addr_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (m_addr_ok !== exp_g[i]) begin n_fail++; $display("FAIL rr_grant%0d: got %b want %b", i, m_addr_ok, exp_g[i]); end
      n_chk++; if (s_addr !== exp_a[i]) begin n_fail++; $display("FAIL rr_addr%0d: got %h want %h", i, s_addr, exp_a[i]); end
      tick;
    end
  endtask

  task automatic test_full;
    logic [2:0] exp_d [4];
    exp_d = '{3'b010, 3'b100, 3'b001, 3'b010};
    m_req = 3'b111; s_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL full_s_req: got %b want 0", s_req); end
    n_chk++; if (m_addr_ok !== 3'b000) begin n_fail++; $display("FAIL full_addr_ok: got %b want 000", m_addr_ok); end
    tick;
    s_data_ok = 1'b1; s_rdata = 32'h0000_0A0A;
    @(negedge clk);
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL full_pop_s_req: got %b want 0", s_req); end
    n_chk++; if (m_data_ok !== 3'b001) begin n_fail++; $display("FAIL full_pop_data_ok: got %b want 001", m_data_ok); end
    tick;
    s_data_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (s_req !== 1'b1) begin n_fail++; $display("FAIL full_unblock_s_req: got %b want 1", s_req); end
    n_chk++; if (m_addr_ok !== 3'b010) begin n_fail++; $display("FAIL full_unblock_grant: got %b want 010", m_addr_ok); end
    tick;
    m_req = 3'b000; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      n_chk++; if (m_data_ok !== exp_d[i]) begin n_fail++; $display("FAIL full_drain%0d: got %b want %b", i, m_data_ok, exp_d[i]); end
      tick;
    end
    s_data_ok = 1'b0;
  endtask

  task automatic test_lock;
    do_reset;
    m_req = 3'b100; s_addr_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      if (i == 1) m_req = 3'b101;
      @(negedge clk);
      n_chk++; if (s_addr !== A2) begin n_fail++; $display("FAIL lock_addr%0d: got %h want %h", i, s_addr, A2); end
      n_chk++; if (m_addr_ok !== 3'b000) begin n_fail++; $display("FAIL lock_wait%0d: got %b want 000", i, m_addr_ok); end
      tick;
    end
    s_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (m_addr_ok !== 3'b100) begin n_fail++; $display("FAIL lock_accept: got %b want 100", m_addr_ok); end
    tick;
    m_req = 3'b001;
    @(negedge clk);
    n_chk++; if (m_addr_ok !== 3'b001) begin n_fail++; $display("FAIL lock_next: got %b want 001", m_addr_ok); end
    tick;
    // Requester 1 gets locked, then withdraws: the bridge must see s_req drop, not requester 0.
    m_req = 3'b010; s_addr_ok = 1'b0;
    tick;
    m_req = 3'b001; s_addr_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (s_req !== 1'b0) begin n_fail++; $display("FAIL lock_drop_s_req: got %b want 0", s_req); end
    n_chk++; if (m_addr_ok !== 3'b000) begin n_fail++; $display("FAIL lock_drop_addr_ok: got %b want 000", m_addr_ok); end
    tick;
    @(negedge clk);
    n_chk++; if (m_addr_ok !== 3'b001) begin n_fail++; $display("FAIL lock_after_drop: got %b want 001", m_addr_ok); end
    tick;
    m_req = 3'b000; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (m_data_ok !== 3'b100) begin n_fail++; $display("FAIL lock_resp0: got %b want 100", m_data_ok); end
    tick;
    @(negedge clk);
    n_chk++; if (m_data_ok !== 3'b001) begin n_fail++; $display("FAIL lock_resp1: got %b want 001", m_data_ok); end
    tick;
    @(negedge clk);
    n_chk++; if (m_data_ok !== 3'b001) begin n_fail++; $display("FAIL lock_resp2: got %b want 001", m_data_ok); end
    tick;
    s_data_ok = 1'b0;
  endtask

  // rr pointer enters at 1: grants 1 then 0 then 2 without relying on request overlap.
  task automatic test_ordering;
    logic [2:0]  reqs  [3];
    logic [2:0]  exp_d [3];
    logic [31:0] rd    [3];
    reqs  = '{3'b010, 3'b001, 3'b100};
    exp_d = '{3'b010, 3'b001, 3'b100};
    rd    = '{32'h1111_0001, 32'h2222_0002, 32'h3333_0003};
    s_addr_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      m_req = reqs[i];
      @(negedge clk);
      n_chk++; if (m_addr_ok !== reqs[i]) begin n_fail++; $display("FAIL ord_accept%0d: got %b want %b", i, m_addr_ok, reqs[i]); end
      tick;
    end
    m_req = 3'b000; s_addr_ok = 1'b0; s_data_ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      s_rdata = rd[i];
      @(negedge clk);
      n_chk++; if (m_data_ok !== exp_d[i]) begin n_fail++; $display("FAIL ord_resp%0d: got %b want %b", i, m_data_ok, exp_d[i]); end
      n_chk++; if (m_rdata !== rd[i]) begin n_fail++; $display("FAIL ord_rdata%0d: got %h want %h", i, m_rdata, rd[i]); end
      tick;
    end
    s_data_ok = 1'b0;
  endtask

  task automatic test_back_to_back_orphan;
    m_req = 3'b001; s_addr_ok = 1'b1;
    tick;
    m_req = 3'b010; s_data_ok = 1'b1;
    @(negedge clk);
    n_chk++; if (m_addr_ok !== 3'b010) begin n_fail++; $display("FAIL b2b_accept: got %b want 010", m_addr_ok); end
    n_chk++; if (m_data_ok !== 3'b001) begin n_fail++; $display("FAIL b2b_resp: got %b want 001", m_data_ok); end
    tick;
    m_req = 3'b000; s_addr_ok = 1'b0;
    @(negedge clk);
    n_chk++; if (m_data_ok !== 3'b010) begin n_fail++; $display("FAIL b2b_resp2: got %b want 010", m_data_ok); end
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL b2b_err: got %b want 0", err); end
    tick;
    @(negedge clk);
    n_chk++; if (m_data_ok !== 3'b000) begin n_fail++; $display("FAIL orphan_data_ok: got %b want 000", m_data_ok); end
    tick;
    s_data_ok = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      n_chk++; if (err !== 1'b1) begin n_fail++; $display("FAIL orphan_err%0d: got %b want 1", i, err); end
      tick;
    end
    do_reset;
    @(negedge clk);
    n_chk++; if (err !== 1'b0) begin n_fail++; $display("FAIL orphan_clear: got %b want 0", err); end
  endtask

  initial begin
    reset = 1'b1; m_req = '0; s_addr_ok = 1'b0; s_data_ok = 1'b0; s_rdata = '0;
    m_wr    = 3'b101;
    m_size  = {2'd2, 2'd1, 2'd0};
    m_addr  = {A2, A1, A0};
    m_wstrb = {4'hF, 4'h3, 4'h1};
    m_wdata = {32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    tick;
    test_reset;
    test_single_read;
    test_round_robin;
    test_full;
    test_lock;
    test_ordering;
    test_back_to_back_orphan;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
